// File: rtl/seq_mul_16_pkg.sv
// seq_mul_16_pkg -- shared types, widths and prefix-adder helper for seq_mul_16.
// Optional feature macro used by the top: SEQ_MUL_EARLY_TERM_EN.
package seq_mul_16_pkg;

    localparam int unsigned MUL_W  = 16;
    localparam int unsigned PROD_W = 32;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One Kogge-Stone combine level at span d; returns {g_next, p_next}.
    function automatic logic [2*MUL_W-1:0] ks_step(
        input logic [MUL_W-1:0] g,
        input logic [MUL_W-1:0] p,
        input int unsigned      d
    );
        logic [MUL_W-1:0] g_n;
        logic [MUL_W-1:0] p_n;
        g_n = g;
        p_n = p;
        for (int unsigned i = 0; i < MUL_W; i++) begin
            if (i >= d) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
        end
        return {g_n, p_n};
    endfunction

endpackage

// File: rtl/seq_mul_16_prefixadder.sv
// prefixadder_16 -- 16-bit Kogge-Stone parallel-prefix adder with carry-in.
module prefixadder_16
    import seq_mul_16_pkg::*;
(
    input  logic [MUL_W-1:0] a,
    input  logic [MUL_W-1:0] b,
    input  logic             cin,
    output logic [MUL_W-1:0] sum,
    output logic             cout
);

    logic [MUL_W-1:0] g0, p0;
    logic [MUL_W-1:0] g1, p1;
    logic [MUL_W-1:0] g2, p2;
    logic [MUL_W-1:0] g3, p3;
    logic [MUL_W-1:0] g4, p4;
    logic [MUL_W:0]   carry;

    // Bitwise generate/propagate and four log-spaced prefix levels.
    always_comb begin
        g0 = a & b;
        p0 = a ^ b;
        {g1, p1} = ks_step(g0, p0, 1);
        {g2, p2} = ks_step(g1, p1, 2);
        {g3, p3} = ks_step(g2, p2, 4);
        {g4, p4} = ks_step(g3, p3, 8);
    end

    // Fold carry-in into the group terms to form every bit's carry.
    always_comb begin
        carry = {g4 | (p4 & {MUL_W{cin}}), cin};
        sum   = p0 ^ carry[MUL_W-1:0];
        cout  = carry[MUL_W];
    end

endmodule

// File: rtl/seq_mul_16.sv
// seq_mul_16 -- 16x16 unsigned shift-and-add multiplier, one multiplier bit
// per cycle through a shared prefix adder.
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish early once the remaining
// multiplier bits are zero by barrel-shifting the partial product into place.
module seq_mul_16
    import seq_mul_16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic              ready,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    state_t            state;
    logic [MUL_W-1:0]  mcand;
    logic [MUL_W-1:0]  mplier;
    logic [MUL_W-1:0]  hi;
    logic [CNT_W-1:0]  count;

    logic [MUL_W-1:0]  addend;
    logic [MUL_W-1:0]  sum;
    logic              cout;
    logic [PROD_W-1:0] step_val;

    prefixadder_16 u_add (
        .a    (hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Select the addend and form the shifted {cout, sum, mplier} >> 1 result.
    always_comb begin
        addend   = mplier[0] ? mcand : '0;
        step_val = {cout, sum, mplier[MUL_W-1:1]};
    end

`ifdef SEQ_MUL_EARLY_TERM_EN
    logic              et_hit;
    logic [CNT_W-1:0]  et_shamt;
    logic [PROD_W-1:0] et_val;

    // The low (16-count) bits of mplier are still unconsumed multiplier bits;
    // when all zero, the remaining steps reduce to a plain right shift.
    always_comb begin
        et_hit   = (mplier & (16'hFFFF >> count)) == '0;
        et_shamt = CNT_W'(5'd16 - count);
        et_val   = {hi, mplier} >> et_shamt;
    end
`endif

    // Control FSM and datapath registers; outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            hi      <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        hi     <= '0;
                        count  <= '0;
                        ready  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
`ifdef SEQ_MUL_EARLY_TERM_EN
                    if (et_hit) begin
                        {hi, mplier} <= et_val;
                        product      <= et_val;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else
`endif
                    begin
                        hi     <= step_val[PROD_W-1:MUL_W];
                        mplier <= step_val[MUL_W-1:0];
                        count  <= count + 1'b1;
                        if (count == CNT_W'(15)) begin
                            product <= step_val;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_mul_16.md
SEQ_MUL_16 -- requirements
Module: seq_mul_16

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16, product width at 32.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; accepted only when ready=1.
REQ-005 a  input  16  multiplicand, unsigned, sampled on accept.
REQ-006 b  input  16  multiplier, unsigned, sampled on accept.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 done  output  1  one-cycle pulse, product valid.
REQ-009 product  output  32  a*b, held until next accept.

Function
REQ-010 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-011 IDLE with start=1 SHALL latch a to mcand, b to mplier, clear hi accumulator and count, and go to RUN.
REQ-012 Each RUN cycle SHALL compute hi+mcand (when mplier LSB=1) or hi+0 through the 16-bit prefix adder with carry-in 0.
REQ-013 Each RUN cycle SHALL then shift the 33-bit value {cout, sum, mplier} right one bit into {hi, mplier} and increment count.
REQ-014 After the 16th RUN cycle the FSM SHALL enter DONE; product={hi, mplier}.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 Accept at edge N SHALL give done=1 in cycle N+17 (early termination out).
REQ-017 start while ready=0 SHALL be ignored, with no queuing.
REQ-018 a and b changing after accept SHALL not affect the result.
REQ-019 product SHALL update only on DONE entry and be stable otherwise.
REQ-020 Back-to-back: start held high SHALL be accepted in the IDLE cycle after DONE.
REQ-021 Final carry-out SHALL never be lost; 0xFFFF*0xFFFF SHALL yield 0xFFFE0001.

Reset
REQ-022 rst_n=0 SHALL force IDLE, ready=1, done=0, product=0, and clear all datapath registers, including mid-RUN.
REQ-023 After rst_n release, the first accept SHALL be possible in the next cycle.

Configuration
REQ-024 With macro SEQ_MUL_EARLY_TERM_EN defined, a RUN cycle whose unconsumed multiplier bits are all zero SHALL barrel-shift {hi, mplier} right by (16-count) and enter DONE.
REQ-025 With SEQ_MUL_EARLY_TERM_EN defined, b=0 SHALL give done at N+2 and b=1 at N+3.
REQ-026 Without SEQ_MUL_EARLY_TERM_EN, latency SHALL always be N+17, with no barrel shifter synthesized.
REQ-027 Product values SHALL be identical with and without the macro.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE), MUL_W=16, PROD_W=32, and count width 5.
REQ-029 The adder SHALL be one instance of the existing prefixadder_16 sub-module; no other sub-module.
REQ-030 The RTL SHALL contain no behavioural '*' or '+' on datapath operands; only the count increment is permitted.

Verification
REQ-031 Reset, then a=3, b=5, start pulse -> ready=0 next cycle; done at N+17; product=0x0000000F.
REQ-032 a=0xFFFF, b=0xFFFF -> product=0xFFFE0001; done high for exactly one cycle.
REQ-033 Accept a=7, b=9, then start=1 with a=1, b=1 during RUN -> ignored; product=0x0000003F.
REQ-034 rst_n=0 at cycle N+8 of a=0x1234, b=0x5678 -> ready=1, product=0, done=0; a new start of 2*2 -> product=4.
REQ-035 SEQ_MUL_EARLY_TERM_EN on, a=0xABCD: b=0 -> done N+2, product 0; b=1 -> done N+3, product 0x0000ABCD; b=0x8000 -> done N+17, product 0x55E68000.
REQ-036 Random 10k operand pairs, both macro settings -> product equals reference a*b; no done without a prior accept.
